// File: rtl/mips_data_memory.sv
// Data memory for the single-cycle MIPS datapath: byte/half/word loads and stores,
// sign/zero extension, programmable wait states. Define DMEM_MISALIGN_TRAP_EN to trap misaligned accesses.
module mips_data_memory #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned WAIT_STATES = 0,
  parameter string       INIT_FILE   = "memory.mem"
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  localparam int unsigned WIDX_W = ADDR_W - 2;
  localparam int unsigned MIDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

  state_t              state;
  logic [3:0]          wait_cnt;
  logic                we_q;
  logic                uns_q;
  logic [1:0]          size_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic                rsp_valid_q;

  logic [31:0]         mem [DEPTH_WORDS];

  logic [WIDX_W-1:0]   word_idx;
  logic [MIDX_W-1:0]   mem_idx;
  logic [1:0]          lane;
  logic                out_of_range;
  logic                bad_size;
  logic                misalign;
  logic                acc_err;
  logic [3:0]          be;
  logic [31:0]         wshift;
  logic [31:0]         rword;
  logic [31:0]         rshift;
  logic [31:0]         load_data;

  initial begin
    for (int unsigned i = 0; i < DEPTH_WORDS; i++) mem[i] = '0;
  end

  always_comb begin
    word_idx     = addr_q[ADDR_W-1:2];
    mem_idx      = word_idx[MIDX_W-1:0];
    out_of_range = 32'(word_idx) >= DEPTH_WORDS;
    bad_size     = (size_q == 2'b11);
`ifdef DMEM_MISALIGN_TRAP_EN
    lane     = addr_q[1:0];
    misalign = ((size_q == 2'b01) && addr_q[0]) ||
               ((size_q == 2'b10) && (addr_q[1:0] != 2'b00));
`else
    // Misaligned low bits are dropped so the access snaps to its natural boundary.
    misalign = 1'b0;
    case (size_q)
      2'b01:   lane = {addr_q[1], 1'b0};
      2'b10:   lane = 2'b00;
      default: lane = addr_q[1:0];
    endcase
`endif
    acc_err = out_of_range | bad_size | misalign;

    case (size_q)
      2'b00:   be = 4'b0001 << lane;
      2'b01:   be = 4'b0011 << lane;
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    wshift = wdata_q << {lane, 3'b000};

    rword  = mem[mem_idx];
    rshift = rword >> {lane, 3'b000};
    case (size_q)
      2'b00:   load_data = uns_q ? {24'b0, rshift[7:0]}  : {{24{rshift[7]}}, rshift[7:0]};
      2'b01:   load_data = uns_q ? {16'b0, rshift[15:0]} : {{16{rshift[15]}}, rshift[15:0]};
      default: load_data = rshift;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      req_ready   <= 1'b1;
      busy        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            we_q      <= req_we;
            size_q    <= req_size;
            uns_q     <= req_unsigned;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            wait_cnt  <= WAIT_LOAD;
            state     <= (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
          end
        end
        S_WAIT: begin
          if (wait_cnt == '0) state <= S_ACCESS;
          else                wait_cnt <= wait_cnt - 4'd1;
        end
        S_ACCESS: begin
          rsp_valid_q <= 1'b1;
          rsp_err     <= acc_err;
          rsp_rdata   <= (acc_err || we_q) ? '0 : load_data;
          state       <= S_RESP;
        end
        S_RESP: begin
          rsp_valid_q <= 1'b0;
          req_ready   <= 1'b1;
          busy        <= 1'b0;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Contents are never reset; only the write strobe is qualified by reset.
  always_ff @(posedge clk) begin
    if (!reset && (state == S_ACCESS) && we_q && !acc_err) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be[b]) mem[mem_idx][8*b +: 8] <= wshift[8*b +: 8];
      end
    end
  end

  // Reset during RESP must cancel the pulse already on the wire.
  assign rsp_valid = rsp_valid_q & ~reset;

endmodule
